// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: merges pipeline writebacks and queued muldiv results onto one registered
// register-file write port, and tracks muldiv destinations still in flight for decode stalls.
module wb_write_arbiter #(
    parameter int AddrL = 5,
    parameter int WL    = 32,
    parameter int Depth = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wb_regwrite,
    input  logic [AddrL-1:0]        wb_reg,
    input  logic [WL-1:0]           wb_data,
    input  logic                    md_valid,
    input  logic [AddrL-1:0]        md_reg,
    input  logic [WL-1:0]           md_data,
    output logic                    md_ready,
    input  logic                    issue_valid,
    input  logic [AddrL-1:0]        issue_reg,
    input  logic [AddrL-1:0]        chk_reg1,
    input  logic [AddrL-1:0]        chk_reg2,
    output logic                    stall,
    output logic                    rf_regwrite,
    output logic [AddrL-1:0]        rf_reg,
    output logic [WL-1:0]           rf_data,
    output logic [$clog2(Depth):0]  pending_cnt,
    output logic                    ovf
);
    localparam int PW = $clog2(Depth);
    localparam int NR = 2 ** AddrL;
    localparam logic [PW:0]   FULL  = (PW+1)'(Depth);
    localparam logic [PW-1:0] P_ONE = PW'(1);

    logic [AddrL-1:0] r_mem_reg [Depth];
    logic [WL-1:0]    r_mem_data [Depth];
    logic [PW-1:0]    r_wp, r_rp;
    logic [PW:0]      r_cnt;
    logic [NR-1:0]    r_pend;
    logic             w_wb_take, w_push, w_pop;
    logic [AddrL-1:0] w_head_reg;
    logic [WL-1:0]    w_head_data;

    assign w_wb_take   = wb_regwrite && (wb_reg != '0);
    assign md_ready    = r_cnt < FULL;
    assign w_push      = md_valid && md_ready;
    assign w_pop       = !w_wb_take && (r_cnt != '0);
    assign w_head_reg  = r_mem_reg[r_rp];
    assign w_head_data = r_mem_data[r_rp];
    assign pending_cnt = r_cnt;
    assign stall       = ((chk_reg1 != '0) && r_pend[chk_reg1]) || ((chk_reg2 != '0) && r_pend[chk_reg2]);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_reg[r_wp]  <= md_reg;
            r_mem_data[r_wp] <= md_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wp        <= '0;
            r_rp        <= '0;
            r_cnt       <= '0;
            r_pend      <= '0;
            rf_regwrite <= 1'b0;
            rf_reg      <= '0;
            rf_data     <= '0;
            ovf         <= 1'b0;
        end else begin
            r_cnt <= r_cnt + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
            if (w_push)
                r_wp <= r_wp + P_ONE;
            if (w_pop)
                r_rp <= r_rp + P_ONE;
            if (md_valid && !md_ready)
                ovf <= 1'b1;
            if (w_wb_take) begin
                rf_regwrite <= 1'b1;
                rf_reg      <= wb_reg;
                rf_data     <= wb_data;
            end else if (w_pop) begin
                rf_regwrite <= w_head_reg != '0;
                rf_reg      <= w_head_reg;
                rf_data     <= w_head_data;
            end else begin
                rf_regwrite <= 1'b0;
            end
            // a coincident issue to the register being retired must leave it pending
            if (w_pop && (w_head_reg != '0))
                r_pend[w_head_reg] <= 1'b0;
            if (issue_valid && (issue_reg != '0))
                r_pend[issue_reg] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter: directed stimulus checked every cycle against a queue-based model,
// plus literal expectations at the scenario points.
module tb_wb_write_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_regwrite, md_valid, issue_valid;
    logic [4:0]  wb_reg, md_reg, issue_reg, chk_reg1, chk_reg2;
    logic [31:0] wb_data, md_data;
    logic        md_ready, stall, rf_regwrite, ovf;
    logic [4:0]  rf_reg;
    logic [31:0] rf_data;
    logic [2:0]  pending_cnt;

    int checks = 0;
    int failures = 0;

    wb_write_arbiter #(.AddrL(5), .WL(32), .Depth(4)) dut (
        .clk(clk), .rst(rst),
        .wb_regwrite(wb_regwrite), .wb_reg(wb_reg), .wb_data(wb_data),
        .md_valid(md_valid), .md_reg(md_reg), .md_data(md_data), .md_ready(md_ready),
        .issue_valid(issue_valid), .issue_reg(issue_reg),
        .chk_reg1(chk_reg1), .chk_reg2(chk_reg2), .stall(stall),
        .rf_regwrite(rf_regwrite), .rf_reg(rf_reg), .rf_data(rf_data),
        .pending_cnt(pending_cnt), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {logic [4:0] r; logic [31:0] d;} ent_t;
    ent_t        q[$];
    bit   [31:0] m_pend;
    logic        m_we, m_ovf, m_known, m_full;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    ent_t        e;

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            q.delete();
            m_pend = '0; m_we = 0; m_reg = 0; m_data = 0; m_ovf = 0; m_known = 1;
        end else begin
            m_full = q.size() == 4;
            if (wb_regwrite && wb_reg != 0) begin
                m_we = 1; m_reg = wb_reg; m_data = wb_data; m_known = 1;
            end else if (q.size() > 0) begin
                e = q.pop_front();
                m_we = e.r != 0; m_reg = e.r; m_data = e.d; m_known = e.r != 0;
                if (e.r != 0) m_pend[e.r] = 1'b0;
            end else begin
                m_we = 0;
            end
            if (md_valid) begin
                if (m_full) m_ovf = 1;
                else q.push_back({md_reg, md_data});
            end
            if (issue_valid && issue_reg != 0) m_pend[issue_reg] = 1'b1;
        end
        #1;
        check("m_rf_regwrite", rf_regwrite, m_we);
        if (m_known) begin
            check("m_rf_reg", rf_reg, m_reg);
            check("m_rf_data", rf_data, m_data);
        end
        check("m_pending_cnt", pending_cnt, q.size());
        check("m_md_ready", md_ready, q.size() < 4);
        check("m_ovf", ovf, m_ovf);
        check("m_stall", stall, (chk_reg1 != 0 && m_pend[chk_reg1]) || (chk_reg2 != 0 && m_pend[chk_reg2]));
    end

    task automatic idle();
        wb_regwrite = 0; wb_reg = 0; wb_data = 0;
        md_valid = 0; md_reg = 0; md_data = 0;
        issue_valid = 0; issue_reg = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] d);
        wb_regwrite = 1; wb_reg = r; wb_data = d;
    endtask

    task automatic md(input logic [4:0] r, input logic [31:0] d);
        md_valid = 1; md_reg = r; md_data = d;
    endtask

    initial begin
        idle(); chk_reg1 = 0; chk_reg2 = 0;
        step(); step();
        check("rst_regwrite", rf_regwrite, 0);
        check("rst_reg", rf_reg, 0);
        check("rst_data", rf_data, 0);
        check("rst_cnt", pending_cnt, 0);
        check("rst_ready", md_ready, 1);
        check("rst_stall", stall, 0);
        check("rst_ovf", ovf, 0);
        rst = 1;

        wb(5, 32'hDEADBEEF); step();
        check("wb_we", rf_regwrite, 1);
        check("wb_reg", rf_reg, 5);
        check("wb_data", rf_data, 32'hDEADBEEF);
        idle(); step();
        check("idle_we", rf_regwrite, 0);
        check("idle_hold", rf_data, 32'hDEADBEEF);
        wb(0, 32'h1); step();
        check("wb0_drop", rf_regwrite, 0);

        idle(); issue_valid = 1; issue_reg = 8; step();
        idle(); md(8, 32'h12); chk_reg1 = 8; step();
        check("md_stall", stall, 1);
        check("md_cnt", pending_cnt, 1);
        idle(); step();
        check("md_pop_we", rf_regwrite, 1);
        check("md_pop_reg", rf_reg, 8);
        check("md_pop_data", rf_data, 32'h12);
        check("md_unstall", stall, 0);
        chk_reg1 = 0;

        for (int i = 0; i < 4; i++) begin
            idle(); wb(1, i); md(5'(10 + i), 32'hA0 + i); step();
        end
        check("full_cnt", pending_cnt, 4);
        check("full_ready", md_ready, 0);
        idle(); wb(1, 9); md(14, 32'hEE); step();
        check("ovf_cnt", pending_cnt, 4);
        check("ovf_set", ovf, 1);
        idle();
        for (int i = 0; i < 4; i++) begin
            step();
            check("fifo_order", rf_reg, 10 + i);
            check("fifo_data", rf_data, 32'hA0 + i);
        end
        step();
        check("drained", pending_cnt, 0);

        for (int i = 0; i < 4; i++) begin
            idle(); wb(2, i); md(5'(16 + i), 32'h100 + i); step();
        end
        idle(); md(20, 32'h200); step();
        check("full_pop_reg", rf_reg, 16);
        check("full_nopush", pending_cnt, 3);
        step();
        check("push_next_reg", rf_reg, 17);
        check("push_next_cnt", pending_cnt, 3);
        for (int i = 21; i <= 28; i++) begin
            idle(); md(5'(i), 32'h200 + i); step();
        end
        idle(); step(); step(); step();
        check("wrap_last", rf_reg, 28);
        check("wrap_data", rf_data, 32'h200 + 28);
        step();
        check("wrap_empty", pending_cnt, 0);

        idle(); issue_valid = 1; issue_reg = 3; step();
        idle(); wb(4, 32'h44); md(3, 32'h33); step();
        idle(); issue_valid = 1; issue_reg = 3; chk_reg2 = 3; step();
        check("setwin_reg", rf_reg, 3);
        check("setwin_stall", stall, 1);
        idle(); md(3, 32'h34); step();
        idle(); step();
        check("clear3_stall", stall, 0);
        chk_reg2 = 0;

        idle(); md(0, 32'h55); step();
        idle(); step();
        check("reg0_pop_we", rf_regwrite, 0);
        check("reg0_pop_cnt", pending_cnt, 0);

        idle(); issue_valid = 1; issue_reg = 6; wb(1, 32'h11); md(6, 32'h66); step();
        idle(); wb(1, 32'h22); md(7, 32'h77); chk_reg1 = 6; step();
        check("pre_rst_cnt", pending_cnt, 2);
        idle();
        rst = 0;
        #1;
        check("arst_we", rf_regwrite, 0);
        check("arst_reg", rf_reg, 0);
        check("arst_data", rf_data, 0);
        check("arst_cnt", pending_cnt, 0);
        check("arst_ovf", ovf, 0);
        check("arst_ready", md_ready, 1);
        check("arst_stall", stall, 0);
        step();
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_we", rf_regwrite, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
